pipe_stage_skid: RTL and testbench

- Parametrised pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, ...). Generalises the fixed 32-bit instruction/PC latch.
- Replaces global stall with a valid/ready handshake and a one-entry skid buffer, so in_ready is fully registered and a full-throughput stage can be backpressured without combinational ready paths.
- Adds a synchronous flush that injects a NOP bubble, plus a saturating backpressure-cycle counter for performance debug.

---
 rtl/pipe_stage_skid_pkg.sv | 26 ++
 rtl/pipe_stage_skid_if.sv | 17 +
 rtl/pipe_stage_skid_sat_counter.sv | 24 ++
 rtl/pipe_stage_skid.sv | 112 +++++++++++
 tb/tb_pipe_stage_skid.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for pipeline-boundary registers.
//   - Per-boundary payload widths and NOP encodings.
//   - {pc, inst} payload struct used at the IF/ID boundary.
//   - Occupancy encoding for the skid-buffered stage register.
package pipe_pkg;

  localparam int unsigned IF_ID_W = 64;
  localparam int unsigned ID_EX_W = 128;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  localparam if_id_t NOP_IF_ID = '{pc: 32'h0000_0000, inst: NOP_INST};

  // E: main empty, M: main only, F: main + skid
  typedef enum logic [1:0] {
    OCC_E = 2'd0,
    OCC_M = 2'd1,
    OCC_F = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready payload channel between pipeline stages.
//   valid : producer has a live payload
//   ready : consumer accepts this cycle
//   data  : payload, DATA_W bits
// master = producer side, slave = consumer side.
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W = 64
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);

endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, synchronous active-high reset
//   inc        : count one this cycle (held at all-ones once reached)
//   clr        : zero the counter; wins over inc
//   cnt        : current count
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid
// buffer, so the upstream ready is a pure register decode with no path from
// the downstream ready. Synchronous flush replaces all held payloads with a
// bubble; a saturating counter records cycles spent backpressured.
//   clk, reset     : clock, synchronous active-high reset
//   flush          : discard held and incoming payloads this cycle
//   in_port        : upstream channel (slave)
//   out_port       : downstream channel (master); data = NOP_VALUE when idle
//   stall_cnt      : cycles with out valid && !out ready, saturating
//   stall_cnt_clr  : synchronous clear of stall_cnt
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned         DATA_W    = IF_ID_W,
  parameter logic [DATA_W-1:0]   NOP_VALUE = '0,
  parameter int unsigned         CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  pipe_stage_skid_if.slave       in_port,
  pipe_stage_skid_if.master      out_port,
  output logic [CNT_W-1:0]       stall_cnt,
  input  logic                   stall_cnt_clr
);

  occ_e              state, state_nxt;
  logic [DATA_W-1:0] main_data, main_data_nxt;
  logic [DATA_W-1:0] skid_data, skid_data_nxt;

  logic main_valid;
  logic skid_valid;
  logic in_fire;
  logic out_fire;

  assign main_valid = (state != OCC_E);
  assign skid_valid = (state == OCC_F);

  assign in_port.ready  = !skid_valid;
  assign out_port.valid = main_valid;
  assign out_port.data  = main_data;

  assign in_fire  = in_port.valid && !skid_valid;
  assign out_fire = main_valid && out_port.ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= OCC_E;
      main_data <= NOP_VALUE;
      skid_data <= NOP_VALUE;
    end else begin
      state     <= state_nxt;
      main_data <= main_data_nxt;
      skid_data <= skid_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    main_data_nxt = main_data;
    skid_data_nxt = skid_data;
    if (flush) begin
      // An input firing this cycle is consumed upstream and simply dropped.
      state_nxt     = OCC_E;
      main_data_nxt = NOP_VALUE;
      skid_data_nxt = NOP_VALUE;
    end else begin
      unique case (state)
        OCC_E: begin
          if (in_fire) begin
            main_data_nxt = in_port.data;
            state_nxt     = OCC_M;
          end
        end
        OCC_M: begin
          if (in_fire && out_fire) begin
            main_data_nxt = in_port.data;
          end else if (out_fire) begin
            main_data_nxt = NOP_VALUE;
            state_nxt     = OCC_E;
          end else if (in_fire) begin
            skid_data_nxt = in_port.data;
            state_nxt     = OCC_F;
          end
        end
        OCC_F: begin
          if (out_fire) begin
            main_data_nxt = skid_data;
            skid_data_nxt = NOP_VALUE;
            state_nxt     = OCC_M;
          end
        end
        default: begin
          state_nxt     = OCC_E;
          main_data_nxt = NOP_VALUE;
          skid_data_nxt = NOP_VALUE;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (main_valid && !out_port.ready),
    .clr   (stall_cnt_clr),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam logic [DW-1:0] NOPV = 32'hDEAD_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          clr;
  logic [CW-1:0] stall_cnt;

  pipe_stage_skid_if #(.DATA_W(DW)) in_bus ();
  pipe_stage_skid_if #(.DATA_W(DW)) out_bus ();

  pipe_stage_skid #(
    .DATA_W    (DW),
    .NOP_VALUE (NOPV),
    .CNT_W     (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_port       (in_bus.slave),
    .out_port      (out_bus.master),
    .stall_cnt     (stall_cnt),
    .stall_cnt_clr (clr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic ov, input logic [DW-1:0] od,
                           input logic ir, input logic [CW-1:0] cnt);
    chk({tag, ".out_valid"}, DW'(out_bus.valid), DW'(ov));
    chk({tag, ".out_data"},  out_bus.data,       od);
    chk({tag, ".in_ready"},  DW'(in_bus.ready),  DW'(ir));
    chk({tag, ".stall_cnt"}, DW'(stall_cnt),     DW'(cnt));
  endtask

  typedef struct {
    logic          rst, fl, iv;
    logic [DW-1:0] d;
    logic          ordy, cl;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic          e_ir;
    logic [CW-1:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(logic rst, logic fl, logic iv, logic [DW-1:0] d, logic ordy,
                              logic cl, logic e_ov, logic [DW-1:0] e_od, logic e_ir,
                              logic [CW-1:0] e_cnt);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy; v.cl = cl;
    v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t vecs[23];

  logic [DW-1:0] q[$];
  logic [DW-1:0] pd;
  logic [DW-1:0] nxt;
  logic          pend;
  logic [CW-1:0] mcnt;
  int            popped;

  initial begin
    reset = 1'b1; flush = 1'b0; clr = 1'b0;
    in_bus.valid = 1'b0; in_bus.data = '0; out_bus.ready = 1'b0;

    //           rst fl iv data        ordy clr | ov od          ir cnt
    vecs[0]  = mk(1, 0, 0, 32'h0,      0,   0,    0, NOPV,       1, 0);
    vecs[1]  = mk(0, 0, 1, 32'h10,     1,   0,    1, 32'h10,     1, 0);
    vecs[2]  = mk(0, 0, 1, 32'h11,     1,   0,    1, 32'h11,     1, 0);
    vecs[3]  = mk(0, 0, 1, 32'h12,     1,   0,    1, 32'h12,     1, 0);
    vecs[4]  = mk(0, 0, 1, 32'h13,     1,   0,    1, 32'h13,     1, 0);
    vecs[5]  = mk(0, 0, 0, 32'h0,      1,   0,    0, NOPV,       1, 0);
    vecs[6]  = mk(0, 0, 1, 32'hA,      0,   0,    1, 32'hA,      1, 0);
    vecs[7]  = mk(0, 0, 1, 32'hB,      0,   0,    1, 32'hA,      0, 1);
    vecs[8]  = mk(0, 0, 1, 32'hC,      0,   0,    1, 32'hA,      0, 2);
    vecs[9]  = mk(0, 0, 0, 32'h0,      0,   0,    1, 32'hA,      0, 3);
    vecs[10] = mk(0, 0, 0, 32'h0,      1,   0,    1, 32'hB,      1, 3);
    vecs[11] = mk(0, 0, 0, 32'h0,      1,   0,    0, NOPV,       1, 3);
    vecs[12] = mk(0, 0, 1, 32'hA,      0,   0,    1, 32'hA,      1, 3);
    vecs[13] = mk(0, 0, 1, 32'hB,      0,   0,    1, 32'hA,      0, 4);
    vecs[14] = mk(0, 1, 1, 32'hC,      0,   0,    0, NOPV,       1, 5);
    vecs[15] = mk(0, 0, 0, 32'h0,      1,   0,    0, NOPV,       1, 5);
    vecs[16] = mk(0, 0, 1, 32'hD,      0,   0,    1, 32'hD,      1, 5);
    vecs[17] = mk(0, 1, 1, 32'hE,      0,   0,    0, NOPV,       1, 6);
    vecs[18] = mk(0, 0, 0, 32'h0,      1,   0,    0, NOPV,       1, 6);
    vecs[19] = mk(0, 0, 1, 32'hA,      0,   0,    1, 32'hA,      1, 6);
    vecs[20] = mk(0, 0, 1, 32'hB,      0,   0,    1, 32'hA,      0, 7);
    vecs[21] = mk(1, 0, 0, 32'h0,      0,   0,    0, NOPV,       1, 0);
    vecs[22] = mk(0, 0, 0, 32'h0,      1,   1,    0, NOPV,       1, 0);

    for (int i = 0; i < 23; i++) begin
      reset = vecs[i].rst; flush = vecs[i].fl; clr = vecs[i].cl;
      in_bus.valid = vecs[i].iv; in_bus.data = vecs[i].d; out_bus.ready = vecs[i].ordy;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ir, vecs[i].e_cnt);
    end

    // Saturation of a 4-bit counter while stalled, then clear beating increment.
    reset = 1'b0; flush = 1'b0; clr = 1'b0;
    in_bus.valid = 1'b1; in_bus.data = 32'h55; out_bus.ready = 1'b0;
    tick();
    check_all("sat_load", 1'b1, 32'h55, 1'b1, 4'd0);
    in_bus.valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_all($sformatf("sat%0d", k), 1'b1, 32'h55, 1'b1, (k > 15) ? 4'd15 : CW'(k));
    end
    clr = 1'b1;
    tick();
    check_all("sat_clr", 1'b1, 32'h55, 1'b1, 4'd0);
    clr = 1'b0;
    tick();
    check_all("sat_resume", 1'b1, 32'h55, 1'b1, 4'd1);
    out_bus.ready = 1'b1;
    tick();
    check_all("sat_drain", 1'b0, NOPV, 1'b1, 4'd1);

    // Random traffic against an in-order queue model (occupancy = queue depth).
    reset = 1'b1; in_bus.valid = 1'b0; out_bus.ready = 1'b0;
    tick();
    reset = 1'b0;
    q.delete(); pend = 1'b0; nxt = 32'h0000_1000; mcnt = '0; popped = 0; pd = '0;
    for (int cyc = 0; cyc < 20000 && popped < 1000; cyc++) begin
      logic iv, ordy, infire, ofire;
      iv = pend ? 1'b1 : 1'($urandom_range(1, 0));
      if (iv && !pend) begin
        pend = 1'b1; pd = nxt; nxt = nxt + 1;
      end
      ordy = 1'($urandom_range(1, 0));
      in_bus.valid = iv; in_bus.data = pd; out_bus.ready = ordy;
      infire = iv && (q.size() < 2);
      ofire  = (q.size() > 0) && ordy;
      if ((q.size() > 0) && !ordy && (mcnt != '1)) mcnt = mcnt + 1'b1;
      tick();
      if (ofire) begin
        void'(q.pop_front());
        popped++;
      end
      if (infire) begin
        q.push_back(pd);
        pend = 1'b0;
      end
      check_all("rand", q.size() > 0, (q.size() > 0) ? q[0] : NOPV, q.size() < 2, mcnt);
    end
    chk("rand_progress", DW'(popped >= 1000), DW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
